// File: rtl/arith_pkg.sv
// Shared types and sizing helpers for the basic-arithmetic library.
package arith_pkg;

  // Control states of the bit-serial arithmetic engines.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } add_state_e;

  // Bit counter width; the extra bit keeps WIDTH=1 at a legal one-bit counter.
  function automatic int unsigned cnt_width(input int unsigned width);
    return unsigned'($clog2(width)) + 32'd1;
  endfunction

endpackage

// File: rtl/half_adder.sv
// Single-bit half adder; two of these plus an OR form a full-adder cell.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  // Sum is the XOR, carry is the AND.
  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-adder cell, LSB first, WIDTH cycles per add.
module serial_adder
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned       CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  add_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic ha0_s, ha0_c, ha1_c, fa_s, fa_c;

  // Full-adder cell built from two half adders.
  half_adder u_ha0 (
    .a (a_sh_q[0]),
    .b (b_sh_q[0]),
    .s (ha0_s),
    .c (ha0_c)
  );

  half_adder u_ha1 (
    .a (ha0_s),
    .b (carry_q),
    .s (fa_s),
    .c (ha1_c)
  );

  assign fa_c = ha0_c | ha1_c;

  // Next-state and datapath update; handshake flags follow the next state so they are registered.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_sh_d  = a;
          b_sh_d  = b;
          sum_d   = '0;
          cnt_d   = '0;
          carry_d = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        sum_d   = (sum_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
        carry_d = fa_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          cout_d  = fa_c;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH = 8, 16 and 1.
module tb_serial_adder;

  logic clk;
  logic rst_n;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, cout8;
  logic [7:0]  a8, b8, sum8;
  logic        in_valid16, in_ready16, out_valid16, out_ready16, cout16;
  logic [15:0] a16, b16, sum16;
  logic        in_valid1, in_ready1, out_valid1, out_ready1, cout1;
  logic [0:0]  a1, b1, sum1;

  logic [8:0]  q8[$];
  logic [16:0] q16[$];
  logic [1:0]  q1[$];

  int n_cmp;
  int n_fail;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16),
    .sum(sum16), .cout(cout16)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair to dut8 (caller ensures in_ready8) and record the expected result.
  task automatic accept8(input logic [7:0] av, input logic [7:0] bv);
    a8 = av;
    b8 = bv;
    in_valid8 = 1'b1;
    q8.push_back({1'b0, av} + {1'b0, bv});
    tick();
    in_valid8 = 1'b0;
  endtask

  // Count edges after acceptance until out_valid8; -1 when the bound expires.
  task automatic wait_out8(output int lat);
    lat = -1;
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (out_valid8) begin
        lat = k;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_handshake8: in_ready=%b out_valid=%b required 1/0", in_ready8, out_valid8);
    end
    n_cmp++;
    if (sum8 !== 8'h00 || cout8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_result8: sum=%h cout=%b required 00/0", sum8, cout8);
    end
    n_cmp++;
    if (in_ready16 !== 1'b1 || out_valid16 !== 1'b0 || in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_others: rdy16=%b vld16=%b rdy1=%b vld1=%b required 1/0/1/0",
               in_ready16, out_valid16, in_ready1, out_valid1);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    logic [8:0] exp;
    out_ready8 = 1'b1;
    accept8(8'h0F, 8'h01);
    wait_out8(lat);
    n_cmp++;
    if (lat !== 8) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d cycles required 8", lat);
    end
    exp = (q8.size() != 0) ? q8.pop_front() : 9'h1FF;
    n_cmp++;
    if ({cout8, sum8} !== exp || exp !== 9'h010) begin
      n_fail++;
      $display("FAIL basic_sum: got %h required %h", {cout8, sum8}, exp);
    end
    n_cmp++;
    if (in_ready8 !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_ready_in_done: got %b required 0", in_ready8);
    end
    // Consumed on this edge; the next accept lands on the tenth edge after the first.
    tick();
    n_cmp++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_drain: in_ready=%b out_valid=%b required 1/0", in_ready8, out_valid8);
    end
  endtask

  task automatic test_corners();
    logic [7:0] ta [4];
    logic [7:0] tb [4];
    int lat;
    logic [8:0] exp;
    ta[0] = 8'hFF; tb[0] = 8'h01;
    ta[1] = 8'hFF; tb[1] = 8'hFF;
    ta[2] = 8'h00; tb[2] = 8'h00;
    ta[3] = 8'h80; tb[3] = 8'h80;
    out_ready8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      accept8(ta[i], tb[i]);
      wait_out8(lat);
      n_cmp++;
      if (lat !== 8) begin
        n_fail++;
        $display("FAIL corner_latency[%0d]: got %0d required 8", i, lat);
      end
      exp = (q8.size() != 0) ? q8.pop_front() : 9'h1FF;
      n_cmp++;
      if ({cout8, sum8} !== exp) begin
        n_fail++;
        $display("FAIL corner_sum[%0d]: got %h required %h", i, {cout8, sum8}, exp);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [8:0] exp;
    out_ready8 = 1'b0;
    accept8(8'h3C, 8'h42);
    // Stray operands during RUN and DONE must be ignored.
    a8 = 8'h55;
    b8 = 8'h55;
    in_valid8 = 1'b1;
    wait_out8(lat);
    n_cmp++;
    if (lat !== 8) begin
      n_fail++;
      $display("FAIL bp_latency: got %0d required 8", lat);
    end
    exp = (q8.size() != 0) ? q8.pop_front() : 9'h1FF;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (out_valid8 !== 1'b1 || in_ready8 !== 1'b0 || {cout8, sum8} !== exp) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: vld=%b rdy=%b res=%h required 1/0/%h",
                 i, out_valid8, in_ready8, {cout8, sum8}, exp);
      end
      tick();
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    tick();
    n_cmp++;
    if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: vld=%b rdy=%b required 0/1", out_valid8, in_ready8);
    end
    accept8(8'h10, 8'hF5);
    wait_out8(lat);
    exp = (q8.size() != 0) ? q8.pop_front() : 9'h1FF;
    n_cmp++;
    if (lat !== 8 || {cout8, sum8} !== exp) begin
      n_fail++;
      $display("FAIL bp_next: lat=%0d res=%h required 8/%h", lat, {cout8, sum8}, exp);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    logic seen;
    logic [8:0] exp;
    out_ready8 = 1'b1;
    a8 = 8'hAB;
    b8 = 8'hCD;
    in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    tick();
    tick();
    tick();
    // Bits 0..2 done; reset lands on the edge that would process bit 3.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_reset: rdy=%b vld=%b sum=%h cout=%b required 1/0/00/0",
               in_ready8, out_valid8, sum8, cout8);
    end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid8) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_discard: got out_valid=%b required 0", seen);
    end
    accept8(8'h12, 8'h34);
    wait_out8(lat);
    exp = (q8.size() != 0) ? q8.pop_front() : 9'h1FF;
    n_cmp++;
    if (lat !== 8 || {cout8, sum8} !== exp || exp !== 9'h046) begin
      n_fail++;
      $display("FAIL midrun_next: lat=%0d res=%h required 8/%h", lat, {cout8, sum8}, exp);
    end
    tick();
  endtask

  task automatic test_width1();
    int lat;
    logic [1:0] exp;
    logic [1:0] ab;
    out_ready1 = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      ab = 2'(i);
      a1 = ab[1];
      b1 = ab[0];
      in_valid1 = 1'b1;
      q1.push_back({1'b0, ab[1]} + {1'b0, ab[0]});
      tick();
      in_valid1 = 1'b0;
      lat = -1;
      for (int k = 1; k <= 8; k++) begin
        tick();
        if (out_valid1) begin
          lat = k;
          break;
        end
      end
      exp = (q1.size() != 0) ? q1.pop_front() : 2'b11;
      n_cmp++;
      if (lat !== 1 || {cout1, sum1} !== exp) begin
        n_fail++;
        $display("FAIL width1[%0d]: lat=%0d res=%b required 1/%b", i, lat, {cout1, sum1}, exp);
      end
      tick();
    end
  endtask

  task automatic test_random8();
    int sent, got, cyc;
    logic [7:0] av, bv;
    logic [8:0] exp;
    sent = 0; got = 0; cyc = 0;
    in_valid8 = 1'b0;
    out_ready8 = 1'b0;
    while (got < 1000 && cyc < 40000) begin
      tick();
      cyc++;
      out_ready8 = ($urandom_range(0, 3) != 0);
      if (out_valid8 && out_ready8) begin
        exp = (q8.size() != 0) ? q8.pop_front() : 9'h1FF;
        n_cmp++;
        if ({cout8, sum8} !== exp) begin
          n_fail++;
          $display("FAIL random8[%0d]: got %h required %h", got, {cout8, sum8}, exp);
        end
        got++;
      end
      if (in_ready8 && sent < 1000) begin
        av = 8'($urandom);
        bv = 8'($urandom);
        a8 = av;
        b8 = bv;
        in_valid8 = 1'b1;
        q8.push_back({1'b0, av} + {1'b0, bv});
        sent++;
      end else begin
        in_valid8 = in_ready8 ? 1'b0 : 1'($urandom_range(0, 1));
        a8 = 8'($urandom);
        b8 = 8'($urandom);
      end
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    n_cmp++;
    if (got !== 1000) begin
      n_fail++;
      $display("FAIL random8_timeout: got %0d results required 1000", got);
    end
  endtask

  task automatic test_random16();
    int sent, got, cyc;
    logic [15:0] av, bv;
    logic [16:0] exp;
    sent = 0; got = 0; cyc = 0;
    in_valid16 = 1'b0;
    out_ready16 = 1'b0;
    while (got < 1000 && cyc < 40000) begin
      tick();
      cyc++;
      out_ready16 = ($urandom_range(0, 3) != 0);
      if (out_valid16 && out_ready16) begin
        exp = (q16.size() != 0) ? q16.pop_front() : 17'h1FFFF;
        n_cmp++;
        if ({cout16, sum16} !== exp) begin
          n_fail++;
          $display("FAIL random16[%0d]: got %h required %h", got, {cout16, sum16}, exp);
        end
        got++;
      end
      if (in_ready16 && sent < 1000) begin
        av = 16'($urandom);
        bv = 16'($urandom);
        a16 = av;
        b16 = bv;
        in_valid16 = 1'b1;
        q16.push_back({1'b0, av} + {1'b0, bv});
        sent++;
      end else begin
        in_valid16 = in_ready16 ? 1'b0 : 1'($urandom_range(0, 1));
        a16 = 16'($urandom);
        b16 = 16'($urandom);
      end
    end
    in_valid16 = 1'b0;
    out_ready16 = 1'b1;
    n_cmp++;
    if (got !== 1000) begin
      n_fail++;
      $display("FAIL random16_timeout: got %0d results required 1000", got);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    in_valid8 = 1'b0;  out_ready8 = 1'b0;  a8 = '0;  b8 = '0;
    in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0;
    in_valid1 = 1'b0;  out_ready1 = 1'b0;  a1 = '0;  b1 = '0;
    #1;
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_reset_mid_run();
    test_width1();
    test_random8();
    test_random16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
